fetch_pipe: RTL and testbench
=============================

# fetch_pipe

Instruction fetch stage for the pipelined-SROM microprocessor. It owns the program counter, drives the program-memory address to the synchronous ROM, and registers the returned word through one pipeline register (`data_pipe`) into the instruction register (`ir`). Each pipeline slot carries a valid bit and its fetch address, so a taken jump from the decode/execute stage squashes the in-flight words. The block sits directly upstream of instruction decode and is the sole driver of `pm_address_out`.

## Interface

Parameters:
- `ADDR_W`, default 8: program-memory address width.
- `DATA_W`, default 8: instruction word width.

Ports:
- `clk`, input, 1: system clock, rising edge.
- `reset`, input, 1: asynchronous, active-low; clears all state.
- `pm_data`, input, `DATA_W`: ROM read data, valid one cycle after its address is on `pm_address_out`.
- `jump_taken`, input, 1: decoder has resolved a taken (un)conditional jump for the instruction in `ir`.
- `jump_target`, input, `ADDR_W`: jump destination address.
- `pm_address_out`, output, `ADDR_W`: registered ROM address.
- `data_pipe`, output, `DATA_W`: pipeline register between ROM and `ir`.
- `ir`, output, `DATA_W`: instruction register presented to decode.
- `ir_valid`, output, 1: `ir` holds a real, non-squashed instruction.
- `pc`, output, `ADDR_W`: fetch address of the word currently in `ir`.

## Operation

- Three slots: ROM slot (address in flight, word arriving on `pm_data`), pipe slot (`data_pipe`) and IR slot (`ir`). Each slot has a `{valid, addr}` tag.
- Every cycle `pm_address_out` advances by 1 mod 2^ADDR_W. The ROM-slot tag takes the old `pm_address_out` with valid = 1. `data_pipe` ← `pm_data` and `ir` ← `data_pipe`, with tags shifting alongside.
- Jump: if `jump_taken && ir_valid` at a rising edge:
  - `pm_address_out` ← `jump_target`.
  - ROM-slot and pipe-slot valid bits are cleared, so the word entering `ir` is squashed.
  - The data registers still load and are don't-care while invalid.
- `jump_taken` with `ir_valid = 0` is ignored.
- `pc` = IR-slot address; `ir_valid` = IR-slot valid.
- Reset values: `pm_address_out` = 0, `data_pipe` = 0, `ir` = 0, `pc` = 0, `ir_valid` = 0, all slot valids = 0.
- Reset mid-operation clears everything immediately and asynchronously. Fetch restarts at address 0 on the first edge after deassertion.

## Timing

- Fetch latency: a word addressed in cycle n appears on `ir` in cycle n+3.
- After reset release, the first edge issues no new address; `pm_address_out` = 0 during cycle 0. `ir` = word[0] with `ir_valid` = 1 in cycle 3.
- Jump penalty: jump resolved in cycle n gives `pm_address_out` = target in cycle n+1, `ir_valid` = 0 in n+1..n+3, and `ir` = word[target] in n+4.
- Address wrap: 2^ADDR_W−1 is followed by 0 with no bubble. `pc` follows the same wrap.
- No stall input: decode consumes one instruction per cycle.

## Structure

- Shared package holds `ADDR_W`/`DATA_W` defaults, the slot tag struct `{valid, addr}` and the `NOP` opcode constant (`ir` reset value 8'h00).
- One natural sub-module, `fetch_slot`: a data register plus tag with load and squash inputs. It is instantiated for the ROM tag (data unused), the pipe slot and the IR slot.
- PC/next-address mux stays in the top level.

## Test plan

- ROM word[a] = a ^ 8'hA5; reset low 3 cycles, then release → `pm_address_out` 0,1,2,…; `ir_valid` rises in cycle 3 with `ir` = 8'hA5, `pc` = 0; next cycle `ir` = 8'hA4, `pc` = 1.
- Pulse `jump_taken` with target 8'h40 while `pc` = 5 → `pm_address_out` = 8'h40 next cycle; `ir_valid` low 3 cycles; then `ir` = 8'hE5, `pc` = 8'h40. Words for 6 and 7 are never valid.
- Hold `jump_taken` = 1 while `ir_valid` = 0 (first cycles after reset) → no redirect; address sequence continues 0,1,2,….
- Jump to 8'hFE → `pc` sequence FE, FF, 00, 01 with `ir_valid` = 1 throughout after fill.
- Assert `reset` asynchronously between edges at `pc` = 8'h23 → all outputs 0 within the same cycle; after release the sequence restarts at 0 with the 3-cycle fill.
- Jump-to-self loop: target = 8'h10, instruction at 8'h10 always jumps → `ir_valid` pattern 1,0,0,0 repeating; `pc` = 8'h10 on every valid cycle.

Source files
------------

// File: rtl/fetch_pipe_pkg.sv
// Shared definitions for the instruction fetch stage: default widths, the
// pipeline slot tag and the NOP opcode used as the register reset value.
package fetch_pipe_pkg;

   localparam int FETCH_ADDR_W = 8;
   localparam int FETCH_DATA_W = 8;

   typedef struct packed {
      logic                    valid;
      logic [FETCH_ADDR_W-1:0] addr;
   } slot_tag_t;

   localparam logic [FETCH_DATA_W-1:0] NOP = 8'h00;

endpackage

// File: rtl/fetch_slot.sv
// One fetch pipeline slot: a data register plus its {valid, addr} tag.
// A squash loads the slot as a bubble; the data is still captured.
module fetch_slot
   import fetch_pipe_pkg::*;
#(
   parameter int ADDR_W = FETCH_ADDR_W,
   parameter int DATA_W = FETCH_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              squash,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_valid,
   input  logic [ADDR_W-1:0] load_addr,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   output logic [ADDR_W-1:0] addr
);

   // NOTE: non-blocking assignments in clocked blocks, so every slot samples
   // the pre-edge value of its upstream neighbour and the pipeline shifts.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data  <= DATA_W'(NOP);
         valid <= 1'b0;
         addr  <= '0;
      end else if (load) begin
         data  <= load_data;
         valid <= load_valid & ~squash;
         addr  <= load_addr;
      end
   end

endmodule

// File: rtl/fetch_pipe.sv
// Instruction fetch stage: program counter, registered ROM address and a
// three-slot tagged pipeline (ROM, data_pipe, ir) with jump squash.
module fetch_pipe
   import fetch_pipe_pkg::*;
#(
   parameter int ADDR_W = FETCH_ADDR_W,
   parameter int DATA_W = FETCH_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] pm_data,
   input  logic              jump_taken,
   input  logic [ADDR_W-1:0] jump_target,
   output logic [ADDR_W-1:0] pm_address_out,
   output logic [DATA_W-1:0] data_pipe,
   output logic [DATA_W-1:0] ir,
   output logic              ir_valid,
   output logic [ADDR_W-1:0] pc
);

   logic              redirect;
   logic              rom_valid;
   logic [ADDR_W-1:0] rom_addr;
   logic              rom_data_unused;
   logic              pipe_valid;
   logic [ADDR_W-1:0] pipe_addr;

   // Only a real instruction in ir may redirect fetch.
   assign redirect = jump_taken & ir_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pm_address_out <= '0;
      end else if (redirect) begin
         pm_address_out <= jump_target;
      end else begin
         pm_address_out <= pm_address_out + 1'b1;
      end
   end

   // The ROM slot only tracks the address in flight; its word is pm_data.
   fetch_slot #(.ADDR_W(ADDR_W), .DATA_W(1)) u_rom_slot (
      .clk        (clk),
      .reset      (reset),
      .load       (1'b1),
      .squash     (redirect),
      .load_data  (1'b0),
      .load_valid (1'b1),
      .load_addr  (pm_address_out),
      .data       (rom_data_unused),
      .valid      (rom_valid),
      .addr       (rom_addr)
   );

   fetch_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pipe_slot (
      .clk        (clk),
      .reset      (reset),
      .load       (1'b1),
      .squash     (redirect),
      .load_data  (pm_data),
      .load_valid (rom_valid),
      .load_addr  (rom_addr),
      .data       (data_pipe),
      .valid      (pipe_valid),
      .addr       (pipe_addr)
   );

   fetch_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ir_slot (
      .clk        (clk),
      .reset      (reset),
      .load       (1'b1),
      .squash     (redirect),
      .load_data  (data_pipe),
      .load_valid (pipe_valid),
      .load_addr  (pipe_addr),
      .data       (ir),
      .valid      (ir_valid),
      .addr       (pc)
   );

endmodule

// File: tb/tb_fetch_pipe.sv
// Scoreboard bench for fetch_pipe: a synchronous ROM model returns a ^ 8'hA5,
// stimulus queues the expected {pc, ir} stream and a monitor checks it.
module tb_fetch_pipe;
   import fetch_pipe_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] pm_data;
   logic       jump_taken;
   logic [7:0] jump_target;
   logic [7:0] pm_address_out;
   logic [7:0] data_pipe;
   logic [7:0] ir;
   logic       ir_valid;
   logic [7:0] pc;

   typedef struct packed {
      logic [7:0] pc;
      logic [7:0] word;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   fetch_pipe #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .pm_data        (pm_data),
      .jump_taken     (jump_taken),
      .jump_target    (jump_target),
      .pm_address_out (pm_address_out),
      .data_pipe      (data_pipe),
      .ir             (ir),
      .ir_valid       (ir_valid),
      .pc             (pc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) pm_data <= pm_address_out ^ 8'hA5;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push_exp(input logic [7:0] a);
      exp_t e;
      e.pc   = a;
      e.word = a ^ 8'hA5;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every valid instruction presented must match the next expected one.
   always @(negedge clk) begin
      if (reset === 1'b1 && ir_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ir: got pc=%0h ir=%0h, expected no valid instruction", pc, ir);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("ir_word", {24'd0, ir}, {24'd0, e.word});
            check("ir_pc", {24'd0, pc}, {24'd0, e.pc});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset       = 1'b0;
      jump_taken  = 1'b0;
      jump_target = 8'h00;
      repeat (3) tick();
      check("rst_addr", {24'd0, pm_address_out}, 32'h0);
      check("rst_pipe", {24'd0, data_pipe}, 32'h0);
      check("rst_ir", {24'd0, ir}, 32'h0);
      check("rst_pc", {24'd0, pc}, 32'h0);
      check("rst_valid", {31'd0, ir_valid}, 32'h0);

      // Cycle 0: release with a jump held high that must be ignored.
      reset       = 1'b1;
      jump_taken  = 1'b1;
      jump_target = 8'h80;
      for (int a = 0; a <= 5; a++) push_exp(8'(a));
      for (int k = 0; k <= 2; k++) begin
         if (k > 0) tick();
         check("fill_addr", {24'd0, pm_address_out}, k);
         check("fill_valid", {31'd0, ir_valid}, 32'h0);
      end
      jump_taken = 1'b0;
      repeat (6) tick();                      // cycle 8: pc = 5
      check("pre_jump_pc", {24'd0, pc}, 32'h5);

      jump_taken  = 1'b1;
      jump_target = 8'h40;
      for (int a = 8'h40; a <= 8'h42; a++) push_exp(8'(a));
      tick();                                 // cycle 9
      jump_taken = 1'b0;
      check("jump_addr", {24'd0, pm_address_out}, 32'h40);
      for (int k = 9; k <= 11; k++) begin
         if (k > 9) tick();
         check("jump_bubble", {31'd0, ir_valid}, 32'h0);
      end
      repeat (3) tick();                      // cycle 14: pc = 0x42

      jump_taken  = 1'b1;
      jump_target = 8'hFE;
      push_exp(8'hFE); push_exp(8'hFF); push_exp(8'h00); push_exp(8'h01);
      tick();                                 // cycle 15
      jump_taken = 1'b0;
      check("wrap_addr_fe", {24'd0, pm_address_out}, 32'hFE);
      tick();
      check("wrap_addr_ff", {24'd0, pm_address_out}, 32'hFF);
      tick();
      check("wrap_addr_00", {24'd0, pm_address_out}, 32'h00);
      repeat (4) tick();                      // cycle 21: pc = 0x01

      jump_taken  = 1'b1;
      jump_target = 8'h20;
      for (int a = 8'h20; a <= 8'h23; a++) push_exp(8'(a));
      tick();                                 // cycle 22
      jump_taken = 1'b0;
      repeat (6) tick();                      // cycle 28: pc = 0x23
      check("pre_reset_pc", {24'd0, pc}, 32'h23);

      // Asynchronous reset between edges, after the monitor has sampled.
      #6;
      reset = 1'b0;
      #1;
      check("async_addr", {24'd0, pm_address_out}, 32'h0);
      check("async_pipe", {24'd0, data_pipe}, 32'h0);
      check("async_ir", {24'd0, ir}, 32'h0);
      check("async_pc", {24'd0, pc}, 32'h0);
      check("async_valid", {31'd0, ir_valid}, 32'h0);
      repeat (2) tick();
      check("held_addr", {24'd0, pm_address_out}, 32'h0);

      reset = 1'b1;                           // cycle 0 again
      push_exp(8'h00);
      for (int k = 0; k <= 2; k++) begin
         if (k > 0) tick();
         check("refill_addr", {24'd0, pm_address_out}, k);
         check("refill_valid", {31'd0, ir_valid}, 32'h0);
      end
      tick();                                 // cycle 3: pc = 0

      // Jump-to-self loop at 0x10, jump_taken held continuously.
      jump_taken  = 1'b1;
      jump_target = 8'h10;
      repeat (4) push_exp(8'h10);
      for (int k = 4; k <= 19; k++) begin
         tick();
         check("loop_valid", {31'd0, ir_valid}, {31'd0, (k >= 7) && ((k - 7) % 4 == 0)});
      end
      tick();
      check("sb_drained", exp_q.size(), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
